regfile_write_queue: RTL and testbench

// Write-back staging queue directly upstream of the 32x32 register array. Buffers

---
 rtl/regfile_write_queue.sv | 72 +++++++
 tb/tb_regfile_write_queue.sv | 139 +++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: write-back staging queue with in-order retire into the register array and read forwarding
module regfile_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     rf_hold,
    output logic [2**ADDR_W-1:0]     rf_we,
    output logic [DATA_W-1:0]        rf_wdata,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 2 ** ADDR_W;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PW-1:0]     head, tail;
    logic [PW-1:0]     idx [DEPTH];
    logic              push, pop;
    assign in_ready = count < CW'(DEPTH);
    assign push     = in_valid && in_ready && in_addr != '0;
    assign pop      = count != '0 && !rf_hold;
    assign rf_we    = pop ? NREG'(1) << addr_q[head] : '0;
    assign rf_wdata = pop ? data_q[head] : '0;
    for (genvar k = 0; k < DEPTH; k++) begin : g_idx
        assign idx[k] = head + PW'(k);
    end
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[idx[i]] && addr_q[idx[i]] == rd_addr && rd_addr != '0) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx[i]];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld_q <= '0;
        end else begin
            if (push) begin
                vld_q[tail] <= 1'b1;
                tail        <= tail + PW'(1);
            end
            if (pop) begin
                vld_q[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= in_addr;
            data_q[tail] <= in_data;
        end
    end
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: vector table, directed corner sequences and random traffic against a queue model
module tb_regfile_write_queue;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, rf_hold, fwd_hit;
    logic [4:0]  in_addr, rd_addr;
    logic [31:0] in_data, rf_we, rf_wdata, fwd_data;
    logic [2:0]  count;
    always #5 clk = ~clk;
    regfile_write_queue dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .rf_hold(rf_hold), .rf_we(rf_we),
        .rf_wdata(rf_wdata), .rd_addr(rd_addr), .fwd_hit(fwd_hit),
        .fwd_data(fwd_data), .count(count)
    );
    typedef struct packed {logic [4:0] a; logic [31:0] d;} ent_t;
    typedef struct {
        logic v; logic [4:0] a; logic [31:0] d; logic h; logic [4:0] r;
        int cnt; logic rdy; logic [31:0] we; logic [31:0] wd; logic hit; logic [31:0] fd;
    } vec_t;
    ent_t q[$];
    vec_t tbl[21];
    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic check_model();
        logic [31:0] ewe, ewd, efd;
        logic ehit;
        ewe = 0; ewd = 0; efd = 0; ehit = 0;
        if (q.size() > 0 && !rf_hold) begin
            ewe = 32'd1 << q[0].a;
            ewd = q[0].d;
        end
        if (rd_addr != 0)
            for (int i = q.size() - 1; i >= 0; i--)
                if (!ehit && q[i].a == rd_addr) begin
                    ehit = 1;
                    efd  = q[i].d;
                end
        chk("model count", 32'(count), q.size());
        chk("model in_ready", 32'(in_ready), 32'(q.size() < 4));
        chk("model rf_we", rf_we, ewe);
        chk("model rf_wdata", rf_wdata, ewd);
        chk("model fwd_hit", 32'(fwd_hit), 32'(ehit));
        chk("model fwd_data", fwd_data, efd);
    endtask
    task automatic cyc(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic h, input logic [4:0] r);
        logic rdy;
        in_valid = v; in_addr = a; in_data = d; rf_hold = h; rd_addr = r;
        #2;
        check_model();
        rdy = q.size() < 4;
        @(posedge clk);
        if (!reset) q.delete();
        else begin
            if (q.size() > 0 && !h) void'(q.pop_front());
            if (v && rdy && a != 0) q.push_back('{a: a, d: d});
        end
        #1;
    endtask
    initial begin
        tbl[0]  = '{1, 1, 32'h101, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[1]  = '{1, 2, 32'h102, 1, 1, 1, 1, 0, 0, 1, 32'h101};
        tbl[2]  = '{1, 3, 32'h103, 1, 2, 2, 1, 0, 0, 1, 32'h102};
        tbl[3]  = '{1, 4, 32'h104, 1, 4, 3, 1, 0, 0, 0, 0};
        tbl[4]  = '{1, 9, 32'h999, 1, 4, 4, 0, 0, 0, 1, 32'h104};
        tbl[5]  = '{0, 0, 0, 0, 9, 4, 0, 32'h2, 32'h101, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 3, 3, 1, 32'h4, 32'h102, 1, 32'h103};
        tbl[7]  = '{0, 0, 0, 0, 3, 2, 1, 32'h8, 32'h103, 1, 32'h103};
        tbl[8]  = '{0, 0, 0, 0, 3, 1, 1, 32'h10, 32'h104, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0};
        tbl[10] = '{1, 7, 32'h11, 1, 7, 0, 1, 0, 0, 0, 0};
        tbl[11] = '{1, 7, 32'h22, 1, 7, 1, 1, 0, 0, 1, 32'h11};
        tbl[12] = '{0, 0, 0, 1, 7, 2, 1, 0, 0, 1, 32'h22};
        tbl[13] = '{0, 0, 0, 0, 7, 2, 1, 32'h80, 32'h11, 1, 32'h22};
        tbl[14] = '{0, 0, 0, 0, 7, 1, 1, 32'h80, 32'h22, 1, 32'h22};
        tbl[15] = '{0, 0, 0, 0, 7, 0, 1, 0, 0, 0, 0};
        tbl[16] = '{1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[18] = '{1, 5, 32'hDEAD_BEEF, 0, 5, 0, 1, 0, 0, 0, 0};
        tbl[19] = '{0, 0, 0, 0, 5, 1, 1, 32'h20, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
        tbl[20] = '{0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0};
        reset = 0; in_valid = 0; in_addr = 0; in_data = 0; rf_hold = 0; rd_addr = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        q.delete();
        for (int i = 0; i < 21; i++) begin
            in_valid = tbl[i].v; in_addr = tbl[i].a; in_data = tbl[i].d;
            rf_hold = tbl[i].h; rd_addr = tbl[i].r;
            #2;
            chk($sformatf("vec%0d count", i), 32'(count), tbl[i].cnt);
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d rf_we", i), rf_we, tbl[i].we);
            chk($sformatf("vec%0d rf_wdata", i), rf_wdata, tbl[i].wd);
            chk($sformatf("vec%0d fwd_hit", i), 32'(fwd_hit), 32'(tbl[i].hit));
            chk($sformatf("vec%0d fwd_data", i), fwd_data, tbl[i].fd);
            cyc(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].h, tbl[i].r);
        end
        for (int i = 0; i < 3; i++) cyc(1, 5'(10 + i), 32'(32'hA0 + i), 1, 0);
        in_valid = 0; rf_hold = 1; rd_addr = 10;
        #2;
        chk("pre-reset count", 32'(count), 3);
        reset = 0;
        cyc(1, 3, 32'h33, 0, 10);
        reset = 1;
        in_valid = 0; rf_hold = 0; rd_addr = 10;
        #2;
        chk("post-reset count", 32'(count), 0);
        chk("post-reset rf_we", rf_we, 0);
        chk("post-reset in_ready", 32'(in_ready), 1);
        chk("post-reset fwd_hit", 32'(fwd_hit), 0);
        cyc(0, 0, 0, 0, 10);
        cyc(1, 1, 32'h600, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1; in_addr = 5'((i % 31) + 1); in_data = 32'h600 + i; rf_hold = 0; rd_addr = 0;
            #2;
            chk($sformatf("wrap%0d count", i), 32'(count), 1);
            chk($sformatf("wrap%0d rf_wdata", i), rf_wdata, 32'h600 + i - 1);
            chk($sformatf("wrap%0d rf_we", i), rf_we, 32'd1 << (((i - 1) % 31) + 1));
            cyc(1, 5'((i % 31) + 1), 32'h600 + i, 0, 0);
        end
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            reset = $urandom_range(0, 49) != 0;
            cyc($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 4) < 2, 5'($urandom_range(0, 7)));
        end
        reset = 1;
        repeat (6) cyc(0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
